reg_scoreboard: RTL

- Register-level hazard scheduler for the in-order RV32 pipeline. Sits between IDU and EXU and gates issue.
- Keeps a per-architectural-register pending-write counter. Increments when a writer issues; decrements when it writes back or is squashed.
- Holds issue while any source operand, or the destination at counter saturation, is pending. Also caps total in-flight writers.
- Replaces combinational pipeline-slot compare with registered state, so any number of younger stages is handled uniformly.

---
 rtl/reg_scoreboard.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// Register-level hazard scoreboard between IDU and EXU. It keeps a pending-write
// counter per architectural register plus an in-flight writer count, and gates issue.
module reg_scoreboard #(
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned MAX_INFLIGHT = 3
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              i_issue_valid,
    input  logic [6:0]                        i_issue_op,
    input  logic [4:0]                        i_issue_rs1,
    input  logic [4:0]                        i_issue_rs2,
    input  logic [4:0]                        i_issue_rd,
    output logic                              o_issue_ready,
    input  logic                              i_wb_valid,
    input  logic [4:0]                        i_wb_rd,
    input  logic                              i_kill_valid,
    input  logic [4:0]                        i_kill_rd,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] o_inflight,
    output logic [31:0]                       o_pending,
    output logic                              o_err
);

    localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned AW = CNT_W + 2;
    localparam int unsigned SW = IW + 2;
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic [IW-1:0]    inflight_q;
    logic [IW-1:0]    inflight_d;
    logic             err_q;
    logic             err_d;

    logic             rs1_used;
    logic             rs2_used;
    logic             writer_op;
    logic             writer;
    logic             stall;
    logic             writer_fire;
    logic [2:0]       applied;

    // Only the major opcode field participates in decode.
    logic unused_op_bits;
    assign unused_op_bits = ^i_issue_op[1:0];

    // Operand usage and destination-write decode.
    always_comb begin
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        writer_op = 1'b0;
        case (i_issue_op[6:2])
            OPC_LOAD:   begin rs1_used = 1'b1; writer_op = 1'b1; end
            OPC_OP_IMM: begin rs1_used = 1'b1; writer_op = 1'b1; end
            OPC_AUIPC:  writer_op = 1'b1;
            OPC_STORE:  begin rs1_used = 1'b1; rs2_used = 1'b1; end
            OPC_OP:     begin rs1_used = 1'b1; rs2_used = 1'b1; writer_op = 1'b1; end
            OPC_LUI:    writer_op = 1'b1;
            OPC_BRANCH: begin rs1_used = 1'b1; rs2_used = 1'b1; end
            OPC_JALR:   begin rs1_used = 1'b1; writer_op = 1'b1; end
            OPC_JAL:    writer_op = 1'b1;
            OPC_SYSTEM: begin rs1_used = 1'b1; writer_op = 1'b1; end
            default:    ;
        endcase
    end

    assign writer = writer_op && (i_issue_rd != 5'd0);

    // Stall looks only at registered state; same-cycle wb/kill never release it.
    always_comb begin
        stall = 1'b0;
        if (rs1_used && (i_issue_rs1 != 5'd0) && (cnt_q[i_issue_rs1] != '0)) stall = 1'b1;
        if (rs2_used && (i_issue_rs2 != 5'd0) && (cnt_q[i_issue_rs2] != '0)) stall = 1'b1;
        if (writer && (cnt_q[i_issue_rd] == CNT_SAT)) stall = 1'b1;
        if (writer && (inflight_q == IW'(MAX_INFLIGHT))) stall = 1'b1;
    end

    assign writer_fire = i_issue_valid && !stall && writer;

    // Per-register counter update with clamp-at-zero; tallies decrements actually applied.
    always_comb begin : cnt_next
        logic          inc;
        logic          wbdec;
        logic          killdec;
        logic [1:0]    dec;
        logic [AW-1:0] avail;
        logic [AW-1:0] rem;
        logic [SW-1:0] up;
        logic [SW-1:0] rem_i;
        inc        = 1'b0;
        wbdec      = 1'b0;
        killdec    = 1'b0;
        dec        = '0;
        avail      = '0;
        rem        = '0;
        up         = '0;
        rem_i      = '0;
        applied    = '0;
        err_d      = err_q;
        inflight_d = inflight_q;
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = '0;
            if (r != 0) begin
                inc     = writer_fire && (i_issue_rd == 5'(r));
                wbdec   = i_wb_valid && (i_wb_rd == 5'(r));
                killdec = i_kill_valid && (i_kill_rd == 5'(r));
                dec     = 2'(wbdec) + 2'(killdec);
                avail   = AW'(cnt_q[r]) + AW'(inc);
                if (AW'(dec) > avail) begin
                    cnt_d[r] = '0;
                    applied  = applied + 3'(avail);
                    err_d    = 1'b1;
                end else begin
                    rem     = avail - AW'(dec);
                    applied = applied + 3'(dec);
                    if (rem > AW'(CNT_SAT)) begin
                        cnt_d[r] = CNT_SAT;
                        err_d    = 1'b1;
                    end else begin
                        cnt_d[r] = CNT_W'(rem);
                    end
                end
            end
        end

        up = SW'(inflight_q) + SW'(writer_fire);
        if (up < SW'(applied)) begin
            inflight_d = '0;
            err_d      = 1'b1;
        end else begin
            rem_i = up - SW'(applied);
            if (rem_i > SW'(MAX_INFLIGHT)) begin
                inflight_d = IW'(MAX_INFLIGHT);
                err_d      = 1'b1;
            end else begin
                inflight_d = IW'(rem_i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        o_pending = '0;
        for (int r = 1; r < 32; r++) o_pending[r] = (cnt_q[r] != '0);
    end

    assign o_issue_ready = !stall;
    assign o_inflight    = inflight_q;
    assign o_err         = err_q;

endmodule
